// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and shared-memory buses around mem_arbiter.
// master = the arbiter's view; slave = the core stages plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              imem_ready;

    logic                dmem_req;
    logic                dmem_write;
    logic [ADDR_W-1:0]   dmem_addr;
    logic [DATA_W-1:0]   dmem_wdata;
    logic [DATA_W/8-1:0] dmem_be;
    logic [DATA_W-1:0]   dmem_rdata;
    logic                dmem_ready;

    logic stall_f_mem;
    logic stall_m_mem;

    // Shared port: mem_req is held until mem_ack; mem_ack is a one-cycle
    // completion that only counts while mem_req is high.
    logic                mem_req;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_write, dmem_addr, dmem_wdata, dmem_be,
        input  mem_rdata, mem_ack,
        output imem_rdata, imem_ready, dmem_rdata, dmem_ready,
        output stall_f_mem, stall_m_mem,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        output imem_req, imem_addr,
        output dmem_req, dmem_write, dmem_addr, dmem_wdata, dmem_be,
        output mem_rdata, mem_ack,
        input  imem_rdata, imem_ready, dmem_rdata, dmem_ready,
        input  stall_f_mem, stall_m_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and the
// data stage; one access at a time, alternating priority under contention.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    mem_arbiter_if.master    bus,
    output logic [1:0]       state_dbg
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic                owner_d;
    logic                last_d;
    logic                abort;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic [DATA_W-1:0]   irdata_q;
    logic [DATA_W-1:0]   drdata_q;
    logic                grant_d;
    logic                grant_i;
    logic                fetch_live;
    logic                iready;
    logic                dready;

    // Data has priority except right after a completed data access.
    assign grant_d    = bus.dmem_req & (~bus.imem_req | ~last_d);
    assign grant_i    = bus.imem_req & ~grant_d;
    assign fetch_live = ~abort & bus.imem_req;

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = BUSY_D;
                else if (grant_i) state_nxt = BUSY_I;
            end
            BUSY_I, BUSY_D: if (bus.mem_ack) state_nxt = DONE;
            DONE:           state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            owner_d  <= 1'b0;
            last_d   <= 1'b0;
            abort    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        owner_d <= 1'b1;
                        we_q    <= bus.dmem_write;
                        addr_q  <= bus.dmem_addr;
                        wdata_q <= bus.dmem_wdata;
                        be_q    <= bus.dmem_be;
                    end else if (grant_i) begin
                        owner_d <= 1'b0;
                        we_q    <= 1'b0;
                        addr_q  <= bus.imem_addr;
                        wdata_q <= '0;
                        be_q    <= '0;
                    end
                end
                BUSY_I: begin
                    // A flushed fetch still completes on the memory side.
                    if (!bus.imem_req) abort <= 1'b1;
                    if (bus.mem_ack) begin
                        if (fetch_live) irdata_q <= bus.mem_rdata;
                        last_d <= 1'b0;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        if (!we_q) drdata_q <= bus.mem_rdata;
                        last_d <= 1'b1;
                    end
                end
                DONE:    abort <= 1'b0;
                default: ;
            endcase
        end
    end

    assign iready = (state == DONE) & ~owner_d & ~abort;
    assign dready = (state == DONE) & owner_d;

    assign bus.mem_req     = (state == BUSY_I) | (state == BUSY_D);
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_be      = be_q;
    assign bus.imem_rdata  = irdata_q;
    assign bus.dmem_rdata  = drdata_q;
    assign bus.imem_ready  = iready;
    assign bus.dmem_ready  = dready;
    assign bus.stall_f_mem = bus.imem_req & ~iready;
    assign bus.stall_m_mem = bus.dmem_req & ~dready;
    assign state_dbg       = state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model plays the memory,
// a monitor pops expected grants/responses and compares against the DUT.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int GW = 70; // {is_d, we, be, addr, wdata}
  localparam int RW = 65; // {is_d, irdata, drdata}

  logic clk = 1'b0;
  logic rst_b;
  logic [1:0] state_dbg;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_b(rst_b), .bus(bus), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [GW-1:0] gnt_q[$];
  logic [RW-1:0] exp_q[$];

  // Reference model knobs, written by the main sequence.
  int fix_wait = 0;
  logic fix_data_en = 1'b0;
  logic [DW-1:0] fix_data = '0;
  logic spur_en = 1'b0;
  int force_ack = 0;
  logic gap_chk = 1'b1;

  // Model: 0 = port free, 1 = access outstanding, 2 = response cycle.
  int phase = 0;
  int wait_n = 0;
  logic m_owner_d = 1'b0, m_last_d = 1'b0, m_abort = 1'b0, m_we = 1'b0;
  logic [DW-1:0] m_irdata = '0, m_drdata = '0;
  logic nxt_iready = 1'b0, nxt_dready = 1'b0;
  logic cur_iready = 1'b0, cur_dready = 1'b0;

  initial begin
    logic win_d;
    bus.mem_ack = 1'b1;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      nxt_iready = 1'b0;
      nxt_dready = 1'b0;
      bus.mem_rdata = $urandom;
      if (!rst_b) begin
        phase = 0; m_last_d = 1'b0; m_abort = 1'b0;
        m_irdata = '0; m_drdata = '0;
        bus.mem_ack = 1'b1;
      end else begin
        bus.mem_ack = 1'b0;
        if (phase != 1) begin
          if (force_ack > 0) begin
            bus.mem_ack = 1'b1;
            force_ack--;
          end else if (spur_en) bus.mem_ack = ($urandom_range(0, 3) == 0);
        end
        case (phase)
          0: if (bus.imem_req || bus.dmem_req) begin
               win_d = bus.dmem_req && (!bus.imem_req || !m_last_d);
               m_owner_d = win_d;
               m_abort = 1'b0;
               m_we = win_d & bus.dmem_write;
               wait_n = (fix_wait >= 0) ? fix_wait : $urandom_range(0, 3);
               if (win_d) gnt_q.push_back({1'b1, bus.dmem_write, bus.dmem_be, bus.dmem_addr, bus.dmem_wdata});
               else       gnt_q.push_back({1'b0, 1'b0, 4'b0, bus.imem_addr, 32'h0});
               phase = 1;
             end
          1: begin
               if (!m_owner_d && !bus.imem_req) m_abort = 1'b1;
               if (wait_n == 0) begin
                 bus.mem_ack = 1'b1;
                 if (fix_data_en) bus.mem_rdata = fix_data;
                 if (m_owner_d) begin
                   if (!m_we) m_drdata = bus.mem_rdata;
                   nxt_dready = 1'b1;
                   exp_q.push_back({1'b1, m_irdata, m_drdata});
                 end else if (!m_abort) begin
                   m_irdata = bus.mem_rdata;
                   nxt_iready = 1'b1;
                   exp_q.push_back({1'b0, m_irdata, m_drdata});
                 end
                 m_last_d = m_owner_d;
                 phase = 2;
               end else wait_n--;
             end
          default: phase = 0;
        endcase
      end
      @(posedge clk);
      cur_iready = nxt_iready;
      cur_dready = nxt_dready;
    end
  end

  // Monitor / scoreboard.
  logic [GW-1:0] cur_g = '0;
  logic prev_req = 1'b0;
  int last_rise = -1;
  initial begin
    logic [RW-1:0] r;
    forever begin
      @(negedge clk);
      check("ready_pulse", 70'({bus.imem_ready, bus.dmem_ready}), 70'({cur_iready, cur_dready}));
      check("stall_f_mem", 70'(bus.stall_f_mem), 70'(bus.imem_req & ~cur_iready));
      check("stall_m_mem", 70'(bus.stall_m_mem), 70'(bus.dmem_req & ~cur_dready));
      if (bus.mem_req && !prev_req) begin
        if (gnt_q.size() == 0) check("unexpected_grant", 70'(1), 70'(0));
        else cur_g = gnt_q.pop_front();
        if (gap_chk && last_rise >= 0) check("grant_gap", 70'(cyc - last_rise), 70'(3));
        last_rise = cyc;
      end
      if (bus.mem_req)
        check("mem_bus", 70'({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata}), 70'(cur_g[68:0]));
      prev_req = bus.mem_req;
      if (bus.imem_ready || bus.dmem_ready) begin
        if (exp_q.size() == 0) check("unexpected_ready", 70'(1), 70'(0));
        else begin
          r = exp_q.pop_front();
          check("ready_owner", 70'({bus.imem_ready, bus.dmem_ready}), 70'({~r[64], r[64]}));
          check("imem_rdata", 70'(bus.imem_rdata), 70'(r[63:32]));
          check("dmem_rdata", 70'(bus.dmem_rdata), 70'(r[31:0]));
        end
      end
    end
  end

  // Random requester driver: holds each request until its ready, may flush fetches.
  task automatic step_rand(input logic allow_new);
    logic ir, dr;
    @(negedge clk);
    ir = bus.imem_ready;
    dr = bus.dmem_ready;
    @(posedge clk); #1;
    if (bus.imem_req) begin
      if (ir) begin
        bus.imem_req = allow_new && ($urandom_range(0, 1) == 1);
        bus.imem_addr = $urandom;
      end else if (allow_new && $urandom_range(0, 15) == 0) bus.imem_req = 1'b0;
    end else if (allow_new && $urandom_range(0, 2) == 0) begin
      bus.imem_req = 1'b1;
      bus.imem_addr = $urandom;
    end
    if ((bus.dmem_req && dr) || (!bus.dmem_req && $urandom_range(0, 2) == 0)) begin
      bus.dmem_req = allow_new && ($urandom_range(0, 1) == 1);
      bus.dmem_write = $urandom_range(0, 1);
      bus.dmem_addr = $urandom;
      bus.dmem_wdata = $urandom;
      bus.dmem_be = BW'($urandom_range(0, 15));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ni, nd, hold;
    logic got;
    logic [DW-1:0] d_old;
    rst_b = 1'b0;
    bus.imem_req = 1'b1; bus.imem_addr = 32'h4000;
    bus.dmem_req = 1'b1; bus.dmem_write = 1'b0; bus.dmem_addr = 32'h3000;
    bus.dmem_wdata = 32'h11112222; bus.dmem_be = 4'hF;

    // Reset with ack and both requests high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 70'(bus.mem_req), 70'(0));
    check("rst_mem_we", 70'(bus.mem_we), 70'(0));
    check("rst_mem_addr", 70'(bus.mem_addr), 70'(0));
    check("rst_mem_wdata", 70'(bus.mem_wdata), 70'(0));
    check("rst_mem_be", 70'(bus.mem_be), 70'(0));
    check("rst_readies", 70'({bus.imem_ready, bus.dmem_ready}), 70'(0));
    check("rst_rdata", 70'({bus.imem_rdata, bus.dmem_rdata}), 70'(0));
    check("rst_state", 70'(state_dbg), 70'(0));
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Continuous contention, zero-wait memory: D, I, D, I.
    ni = 0; nd = 0;
    for (int k = 0; k < 40 && !(ni >= 2 && nd >= 2); k++) begin
      @(negedge clk);
      if (bus.dmem_ready) nd++;
      if (bus.imem_ready) ni++;
      if (k == 1) check("first_grant_data", 70'(bus.mem_addr), 70'(32'h3000));
      @(posedge clk); #1;
    end
    bus.imem_req = 1'b0;
    bus.dmem_req = 1'b0;
    gap_chk = 1'b0;
    check("contention_iready_cnt", 70'(ni), 70'(2));
    check("contention_dready_cnt", 70'(nd), 70'(2));

    // Single fetch, ack 3 cycles after mem_req rises.
    fix_wait = 3; fix_data_en = 1'b1; fix_data = 32'h00500093;
    bus.imem_addr = 32'h100; bus.imem_req = 1'b1;
    got = 1'b0; hold = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.imem_ready) begin
        got = 1'b1;
        check("fetch_rdata", 70'(bus.imem_rdata), 70'(32'h00500093));
      end else begin
        check("fetch_stall", 70'(bus.stall_f_mem), 70'(1));
        if (bus.mem_req) begin
          hold++;
          check("fetch_addr", 70'({bus.mem_we, bus.mem_addr}), 70'({1'b0, 32'h100}));
        end
      end
      @(posedge clk); #1;
    end
    bus.imem_req = 1'b0;
    check("fetch_done", 70'(got), 70'(1));
    check("fetch_hold_cycles", 70'(hold), 70'(4));

    // Store: rdata must not change.
    fix_wait = 2;
    d_old = m_drdata;
    bus.dmem_write = 1'b1; bus.dmem_addr = 32'h2004;
    bus.dmem_wdata = 32'hDEADBEEF; bus.dmem_be = 4'b0011; bus.dmem_req = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.mem_req)
        check("store_bus", 70'({bus.mem_we, bus.mem_be, bus.mem_wdata}), 70'({1'b1, 4'b0011, 32'hDEADBEEF}));
      if (bus.dmem_ready) begin
        got = 1'b1;
        check("store_rdata_hold", 70'(bus.dmem_rdata), 70'(d_old));
      end
      @(posedge clk); #1;
    end
    bus.dmem_req = 1'b0; bus.dmem_write = 1'b0;
    check("store_done", 70'(got), 70'(1));

    // Fetch abort with a data request arriving mid-flight.
    fix_wait = 4; fix_data = 32'hFFFFFFFF;
    bus.imem_addr = 32'h200; bus.imem_req = 1'b1;   // cycle T
    @(posedge clk); #1;
    bus.imem_req = 1'b0;                            // T+1
    @(negedge clk);
    check("abort_mem_req", 70'(bus.mem_req), 70'(1));
    @(posedge clk); #1;
    bus.dmem_addr = 32'h2008; bus.dmem_req = 1'b1;  // T+2
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_mem_req_hold", 70'({bus.mem_req, bus.imem_ready}), 70'({1'b1, 1'b0}));
      @(posedge clk); #1;
    end
    @(negedge clk);                                 // A+1
    check("abort_no_ready", 70'({bus.imem_ready, bus.mem_req}), 70'(0));
    check("abort_rdata_kept", 70'(bus.imem_rdata), 70'(32'h00500093));
    @(posedge clk); #1;                             // A+2: grant
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_next_grant", 70'({bus.mem_req, bus.mem_addr}), 70'({1'b1, 32'h2008}));
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.dmem_ready;
      @(posedge clk); #1;
    end
    bus.dmem_req = 1'b0;
    check("abort_data_done", 70'(got), 70'(1));

    // Reset in the middle of a data access, then a stray ack.
    fix_data_en = 1'b0; fix_wait = 3;
    bus.dmem_addr = 32'h2010; bus.dmem_req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_busy", 70'(bus.mem_req), 70'(1));
    @(posedge clk); #1;
    rst_b = 1'b0; bus.dmem_req = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1; force_ack = 2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_quiet", 70'({bus.mem_req, bus.imem_ready, bus.dmem_ready, state_dbg}), 70'(0));
      check("midrst_rdata", 70'(bus.dmem_rdata), 70'(0));
      @(posedge clk); #1;
    end

    // Randomized traffic with random latency and stray acks.
    fix_wait = -1; spur_en = 1'b1;
    for (int k = 0; k < 3000; k++) step_rand(1'b1);
    for (int k = 0; k < 80 && (bus.imem_req || bus.dmem_req); k++) step_rand(1'b0);
    check("drain_reqs", 70'({bus.imem_req, bus.dmem_req}), 70'(0));
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("exp_q_empty", 70'(exp_q.size()), 70'(0));
    check("gnt_q_empty", 70'(gnt_q.size()), 70'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
